// File: rtl/ysyx_22040127_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040127_mem_stage_pkg
// Desc     : Bus widths, field offsets, size encodings and FSM states for MEM.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22040127_mem_stage_pkg;

  localparam int EX_TO_MEM_WIDTH = 261;
  localparam int MEM_TO_WB_WIDTH = 192;
  localparam int PASS_WIDTH      = 128;

  // ex_to_mem_bus = {pass, alu_result, st_data, mem_re, mem_we, mem_size, mem_unsigned}
  localparam int E_MEM_UNSIGNED = 0;
  localparam int E_MEM_SIZE_LO  = 1;
  localparam int E_MEM_WE       = 3;
  localparam int E_MEM_RE       = 4;
  localparam int E_ST_DATA_LO   = 5;
  localparam int E_ALU_LO       = 69;
  localparam int E_PASS_LO      = 133;

  localparam int P_RD_LO   = 0;
  localparam int P_REG_WEN = 5;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } mem_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 8'h01;
      SIZE_H:  return 8'h03;
      SIZE_W:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22040127_mem_align.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040127_mem_align
// Desc     : Store strobe/data lane shifting and load extract/extend.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040127_mem_align
  import ysyx_22040127_mem_stage_pkg::*;
(
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [63:0] st_data,
  input  logic [63:0] rdata,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata,
  output logic [63:0] ld_data
);

  logic [5:0]  w_shamt;
  logic [63:0] w_rshift;

  assign w_shamt  = {addr_lo, 3'b000};
  // Strobe bits pushed past lane 7 fall off the 8-bit result.
  assign wstrb    = size_mask(size) << addr_lo;
  assign wdata    = st_data << w_shamt;
  assign w_rshift = rdata >> w_shamt;

  always_comb begin
    ld_data = w_rshift;
    case (size)
      SIZE_B: ld_data = is_unsigned ? {56'd0, w_rshift[7:0]}
                                    : {{56{w_rshift[7]}}, w_rshift[7:0]};
      SIZE_H: ld_data = is_unsigned ? {48'd0, w_rshift[15:0]}
                                    : {{48{w_rshift[15]}}, w_rshift[15:0]};
      SIZE_W: ld_data = is_unsigned ? {32'd0, w_rshift[31:0]}
                                    : {{32{w_rshift[31]}}, w_rshift[31:0]};
      default: ld_data = w_rshift;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22040127_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040127_mem_stage
// Desc     : MEM pipeline stage: one data-memory request per load/store, WB handoff.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040127_mem_stage
  import ysyx_22040127_mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ex_to_mem_valid,
  input  logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_bus,
  output logic                       mem_allowin,
  output logic                       mem_to_wb_valid,
  output logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_bus,
  input  logic                       wb_allowin,
  input  logic                       flush,
  output logic                       mem_flush,
  output logic                       dmem_req_valid,
  input  logic                       dmem_req_ready,
  output logic                       dmem_req_we,
  output logic [63:0]                dmem_req_addr,
  output logic [63:0]                dmem_req_wdata,
  output logic [7:0]                 dmem_req_wstrb,
  input  logic                       dmem_resp_valid,
  input  logic [63:0]                dmem_resp_rdata,
  output logic                       mem_fwd_valid,
  output logic [4:0]                 mem_fwd_rd,
  output logic [63:0]                mem_fwd_data,
  output logic                       mem_fwd_block
);

  mem_state_e                 r_state;
  mem_state_e                 w_state_nxt;
  logic                       r_mem_valid;
  logic                       w_mem_valid_nxt;
  logic [EX_TO_MEM_WIDTH-1:0] r_bus;
  logic [63:0]                r_ld;

  logic [PASS_WIDTH-1:0] w_pass;
  logic [63:0]           w_alu;
  logic [63:0]           w_st_data;
  logic                  w_re;
  logic                  w_we;
  logic [1:0]            w_size;
  logic                  w_unsigned;
  logic [63:0]           w_ld_aligned;
  logic [63:0]           w_reg_wdata;
  logic                  w_ready_go;
  logic                  w_accept;
  logic                  w_in_mem_op;

  assign w_pass     = r_bus[E_PASS_LO +: PASS_WIDTH];
  assign w_alu      = r_bus[E_ALU_LO +: 64];
  assign w_st_data  = r_bus[E_ST_DATA_LO +: 64];
  assign w_re       = r_bus[E_MEM_RE];
  assign w_we       = r_bus[E_MEM_WE];
  assign w_size     = r_bus[E_MEM_SIZE_LO +: 2];
  assign w_unsigned = r_bus[E_MEM_UNSIGNED];

  // IDLE with a valid instruction only ever holds a non-memory op.
  assign w_ready_go      = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign mem_allowin     = (r_state != ST_DRAIN) && (!r_mem_valid || (w_ready_go && wb_allowin));
  assign w_accept        = ex_to_mem_valid && mem_allowin && !flush;
  assign w_in_mem_op     = ex_to_mem_bus[E_MEM_RE] | ex_to_mem_bus[E_MEM_WE];
  assign mem_to_wb_valid = r_mem_valid && w_ready_go && !flush;
  assign mem_flush       = flush;

  assign dmem_req_valid = (r_state == ST_REQ) && !flush;
  assign dmem_req_we    = w_we;
  assign dmem_req_addr  = w_alu;

  ysyx_22040127_mem_align u_align (
    .addr_lo     (w_alu[2:0]),
    .size        (w_size),
    .is_unsigned (w_unsigned),
    .st_data     (w_st_data),
    .rdata       (dmem_resp_rdata),
    .wstrb       (dmem_req_wstrb),
    .wdata       (dmem_req_wdata),
    .ld_data     (w_ld_aligned)
  );

  assign w_reg_wdata   = w_re ? r_ld : w_alu;
  assign mem_to_wb_bus = {w_pass, w_reg_wdata};

  assign mem_fwd_valid = r_mem_valid && w_pass[P_REG_WEN] && (w_pass[P_RD_LO +: 5] != 5'd0);
  assign mem_fwd_rd    = w_pass[P_RD_LO +: 5];
  assign mem_fwd_data  = w_reg_wdata;
  assign mem_fwd_block = r_mem_valid && w_re && (r_state != ST_DONE);

  always_comb begin
    w_mem_valid_nxt = r_mem_valid;
    if (flush) begin
      w_mem_valid_nxt = 1'b0;
    end else if (mem_allowin) begin
      w_mem_valid_nxt = w_accept;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_in_mem_op) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (flush)               w_state_nxt = ST_IDLE;
        else if (dmem_req_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A flush that coincides with the response has nothing left to drain.
        if (dmem_resp_valid) w_state_nxt = flush ? ST_IDLE : ST_DONE;
        else if (flush)      w_state_nxt = ST_DRAIN;
      end
      ST_DONE: begin
        if (flush)           w_state_nxt = ST_IDLE;
        else if (wb_allowin) w_state_nxt = (w_accept && w_in_mem_op) ? ST_REQ : ST_IDLE;
      end
      ST_DRAIN: begin
        if (dmem_resp_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mem_valid <= 1'b0;
      r_bus       <= '0;
      r_ld        <= 64'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      if (w_accept) r_bus <= ex_to_mem_bus;
      if ((r_state == ST_WAIT) && dmem_resp_valid && !flush) r_ld <= w_ld_aligned;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040127_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040127_mem_stage
// Desc     : Directed scoreboard bench for the MEM stage with an in-order responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040127_mem_stage;
  import ysyx_22040127_mem_stage_pkg::*;

  logic                       clk;
  logic                       rst_n;
  logic                       ex_to_mem_valid;
  logic [EX_TO_MEM_WIDTH-1:0] ex_to_mem_bus;
  logic                       mem_allowin;
  logic                       mem_to_wb_valid;
  logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_bus;
  logic                       wb_allowin;
  logic                       flush;
  logic                       mem_flush;
  logic                       dmem_req_valid;
  logic                       dmem_req_ready;
  logic                       dmem_req_we;
  logic [63:0]                dmem_req_addr;
  logic [63:0]                dmem_req_wdata;
  logic [7:0]                 dmem_req_wstrb;
  logic                       dmem_resp_valid;
  logic [63:0]                dmem_resp_rdata;
  logic                       mem_fwd_valid;
  logic [4:0]                 mem_fwd_rd;
  logic [63:0]                mem_fwd_data;
  logic                       mem_fwd_block;

  ysyx_22040127_mem_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_to_mem_valid (ex_to_mem_valid),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .mem_allowin     (mem_allowin),
    .mem_to_wb_valid (mem_to_wb_valid),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .wb_allowin      (wb_allowin),
    .flush           (flush),
    .mem_flush       (mem_flush),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_req_we     (dmem_req_we),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_req_wstrb  (dmem_req_wstrb),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_rdata (dmem_resp_rdata),
    .mem_fwd_valid   (mem_fwd_valid),
    .mem_fwd_rd      (mem_fwd_rd),
    .mem_fwd_data    (mem_fwd_data),
    .mem_fwd_block   (mem_fwd_block)
  );

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  req_t        req_q[$];
  logic [63:0] rsp_q[$];
  logic [63:0] wb_q[$];
  logic [4:0]  wbrd_q[$];

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int last_xfer_cycle = -1;
  int resp_delay = 0;

  logic        rsp_pend;
  int          rsp_wcnt;
  logic [63:0] rsp_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EX_TO_MEM_WIDTH-1:0] mk(input logic [4:0] rd, input logic wen,
      input logic [63:0] alu, input logic [63:0] st, input logic re, input logic we,
      input logic [1:0] size, input logic uns);
    logic [127:0] pass;
    pass = {12'h0, 64'h0, 5'h0, 9'h0, 32'h8000_0000, wen, rd};
    return {pass, alu, st, re, we, size, uns};
  endfunction

  function automatic logic [63:0] ld_model(input logic [63:0] rdata, input logic [2:0] off,
      input logic [1:0] size, input logic uns);
    logic [63:0] v;
    int nb;
    nb = 1 << size;
    v  = 64'd0;
    for (int i = 0; i < nb; i++)
      if (off + i < 8) v[i*8 +: 8] = rdata[(off + i)*8 +: 8];
    if (!uns)
      for (int b = nb*8; b < 64; b++) v[b] = v[nb*8-1];
    return v;
  endfunction

  // In-order responder: one response, resp_delay cycles after the cycle following acceptance.
  initial begin
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = 64'd0;
    rsp_pend = 1'b0;
    rsp_wcnt = 0;
    rsp_data = 64'd0;
    forever begin
      @(posedge clk);
      #1;
      dmem_resp_valid = 1'b0;
      dmem_resp_rdata = 64'd0;
      if (rsp_pend) begin
        if (rsp_wcnt == 0) begin
          dmem_resp_valid = 1'b1;
          dmem_resp_rdata = rsp_data;
          rsp_pend = 1'b0;
        end else begin
          rsp_wcnt--;
        end
      end
      @(negedge clk);
      if (rst_n && dmem_req_valid && dmem_req_ready) begin
        if (req_q.size() == 0) begin
          chk("req_unexpected", 64'd1, 64'd0);
        end else begin
          req_t e;
          e = req_q.pop_front();
          chk("req_we", 64'(dmem_req_we), 64'(e.we));
          chk("req_addr", dmem_req_addr, e.addr);
          if (e.we) begin
            chk("req_wdata", dmem_req_wdata, e.wdata);
            chk("req_wstrb", 64'(dmem_req_wstrb), 64'(e.wstrb));
          end
        end
        rsp_data = (rsp_q.size() != 0) ? rsp_q.pop_front() : 64'd0;
        rsp_pend = 1'b1;
        rsp_wcnt = resp_delay;
      end
    end
  end

  // WB-side scoreboard: pop one expected entry per transfer.
  initial forever begin
    @(negedge clk);
    if (rst_n && mem_to_wb_valid && wb_allowin) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        logic [4:0]  r;
        e = wb_q.pop_front();
        r = wbrd_q.pop_front();
        chk("wb_data", mem_to_wb_bus[63:0], e);
        chk("wb_rd", 64'(mem_to_wb_bus[68:64]), 64'(r));
      end
      last_xfer_cycle = cycle;
    end
  end

  task automatic send(input logic [EX_TO_MEM_WIDTH-1:0] bus, input logic has_wb,
      input logic [63:0] exp_wb, input logic has_req, input req_t rq,
      input logic [63:0] rdata, output int acc_cycle);
    logic ok;
    ok = 1'b0;
    acc_cycle = -1;
    ex_to_mem_valid = 1'b1;
    ex_to_mem_bus   = bus;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (mem_allowin && !flush) ok = 1'b1;
    end
    chk("accept_timeout", 64'(ok), 64'd1);
    if (ok) begin
      acc_cycle = cycle;
      if (has_wb) begin
        wb_q.push_back(exp_wb);
        wbrd_q.push_back(bus[E_PASS_LO +: 5]);
      end
      if (has_req) begin
        req_q.push_back(rq);
        rsp_q.push_back(rdata);
      end
    end
    @(posedge clk);
    #1;
    ex_to_mem_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 40 && (wb_q.size() != 0 || req_q.size() != 0 || rsp_pend); n++)
      @(negedge clk);
    chk(tag, 64'(wb_q.size() + req_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_t        rq;
    int          acc;
    int          acc_b;
    logic [63:0] exp_v;
    logic        seen;

    rst_n = 1'b0;
    ex_to_mem_valid = 1'b0;
    ex_to_mem_bus = '0;
    wb_allowin = 1'b1;
    flush = 1'b0;
    dmem_req_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_allowin", 64'(mem_allowin), 64'd1);
    chk("rst_wb_valid", 64'(mem_to_wb_valid), 64'd0);
    chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("rst_fwd", 64'({mem_fwd_valid, mem_fwd_block, mem_flush}), 64'd0);
    chk("rst_wb_bus", mem_to_wb_bus[63:0], 64'd0);
    chk("rst_req_addr", dmem_req_addr, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ALU op: result visible one cycle after accept
    rq = '0;
    send(mk(5'd5, 1'b1, 64'h1234, 64'd0, 1'b0, 1'b0, 2'd3, 1'b0), 1'b1, 64'h1234, 1'b0, rq, 64'd0, acc);
    @(negedge clk);
    chk("alu_wb_valid", 64'(mem_to_wb_valid), 64'd1);
    chk("alu_fwd_block", 64'(mem_fwd_block), 64'd0);
    chk("alu_fwd_valid", 64'(mem_fwd_valid), 64'd1);
    chk("alu_fwd_rd", 64'(mem_fwd_rd), 64'd5);
    chk("alu_fwd_data", mem_fwd_data, 64'h1234);
    @(posedge clk);
    #1;
    drain("alu_drain");

    // lb / lbu at byte 3
    rq = '{we: 1'b0, addr: 64'h1000_0003, wdata: 64'd0, wstrb: 8'd0};
    send(mk(5'd6, 1'b1, 64'h1000_0003, 64'd0, 1'b1, 1'b0, SIZE_B, 1'b0), 1'b1,
         64'hFFFF_FFFF_FFFF_FF80, 1'b1, rq, 64'h0000_0000_8000_0000, acc);
    @(negedge clk);
    chk("lb_fwd_block", 64'(mem_fwd_block), 64'd1);
    @(posedge clk);
    #1;
    drain("lb_drain");
    send(mk(5'd6, 1'b1, 64'h1000_0003, 64'd0, 1'b1, 1'b0, SIZE_B, 1'b1), 1'b1,
         64'h80, 1'b1, rq, 64'h0000_0000_8000_0000, acc);
    drain("lbu_drain");

    // sh at byte 6: WB only after the write response
    rq = '{we: 1'b1, addr: 64'h2000_0006, wdata: 64'hBEEF_0000_0000_0000, wstrb: 8'hC0};
    send(mk(5'd0, 1'b0, 64'h2000_0006, 64'hBEEF, 1'b0, 1'b1, SIZE_H, 1'b0), 1'b1,
         64'h2000_0006, 1'b1, rq, 64'd0, acc);
    @(negedge clk);
    chk("sh_req_cycle_wbv", 64'(mem_to_wb_valid), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("sh_wait_cycle_wbv", 64'(mem_to_wb_valid), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("sh_done_cycle_wbv", 64'(mem_to_wb_valid), 64'd1);
    @(posedge clk);
    #1;
    drain("sh_drain");

    // ld with ready low 3 cycles, then WB back-pressure 2 cycles in DONE
    dmem_req_ready = 1'b0;
    wb_allowin = 1'b0;
    exp_v = ld_model(64'h1122_3344_5566_7788, 3'd0, SIZE_D, 1'b0);
    rq = '{we: 1'b0, addr: 64'h3000_0010, wdata: 64'd0, wstrb: 8'd0};
    send(mk(5'd7, 1'b1, 64'h3000_0010, 64'd0, 1'b1, 1'b0, SIZE_D, 1'b0), 1'b1,
         exp_v, 1'b1, rq, 64'h1122_3344_5566_7788, acc);
    repeat (3) begin
      @(negedge clk);
      chk("stall_req_valid", 64'(dmem_req_valid), 64'd1);
      chk("stall_req_addr", dmem_req_addr, 64'h3000_0010);
      chk("stall_allowin", 64'(mem_allowin), 64'd0);
      @(posedge clk);
      #1;
    end
    dmem_req_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (mem_to_wb_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("stall_done_timeout", 64'(seen), 64'd1);
    for (int k = 0; k < 2; k++) begin
      if (k != 0) @(negedge clk);
      chk("hold_wb_valid", 64'(mem_to_wb_valid), 64'd1);
      chk("hold_wb_data", mem_to_wb_bus[63:0], exp_v);
      chk("hold_allowin", 64'(mem_allowin), 64'd0);
      @(posedge clk);
      #1;
    end
    wb_allowin = 1'b1;
    drain("stall_drain");

    // flush coinciding with req_ready in REQ: no request issued
    rq = '0;
    send(mk(5'd8, 1'b1, 64'h3800_0000, 64'd0, 1'b1, 1'b0, SIZE_W, 1'b0), 1'b0, 64'd0, 1'b0, rq, 64'd0, acc);
    flush = 1'b1;
    @(negedge clk);
    chk("flreq_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("flreq_mem_flush", 64'(mem_flush), 64'd1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flreq_allowin", 64'(mem_allowin), 64'd1);
    chk("flreq_req_after", 64'(dmem_req_valid), 64'd0);
    @(posedge clk);
    #1;

    // flush in WAIT: DRAIN swallows the late response
    resp_delay = 3;
    rq = '{we: 1'b0, addr: 64'h4000_0004, wdata: 64'd0, wstrb: 8'd0};
    send(mk(5'd9, 1'b1, 64'h4000_0004, 64'd0, 1'b1, 1'b0, SIZE_W, 1'b0), 1'b0, 64'd0, 1'b1, rq,
         64'hDEAD_BEEF_CAFE_F00D, acc);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flwait_mem_flush", 64'(mem_flush), 64'd1);
    chk("flwait_wb_valid", 64'(mem_to_wb_valid), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("drain_allowin", 64'(mem_allowin), 64'd0);
    chk("drain_fwd_valid", 64'(mem_fwd_valid), 64'd0);
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      if (mem_allowin) seen = 1'b1;
    end
    chk("drain_exit", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    resp_delay = 0;
    drain("flush_drain");

    // Back-to-back loads: second accepted on the first's transfer edge
    rq = '{we: 1'b0, addr: 64'h5000_0002, wdata: 64'd0, wstrb: 8'd0};
    send(mk(5'd10, 1'b1, 64'h5000_0002, 64'd0, 1'b1, 1'b0, SIZE_H, 1'b0), 1'b1,
         ld_model(64'h0102_0304_F5F6_F7F8, 3'd2, SIZE_H, 1'b0), 1'b1, rq, 64'h0102_0304_F5F6_F7F8, acc);
    rq = '{we: 1'b0, addr: 64'h5000_0004, wdata: 64'd0, wstrb: 8'd0};
    send(mk(5'd11, 1'b1, 64'h5000_0004, 64'd0, 1'b1, 1'b0, SIZE_W, 1'b1), 1'b1,
         ld_model(64'h89AB_CDEF_0000_0000, 3'd4, SIZE_W, 1'b1), 1'b1, rq, 64'h89AB_CDEF_0000_0000, acc_b);
    chk("b2b_same_edge", 64'(acc_b), 64'(last_xfer_cycle));
    drain("b2b_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
